// File: rtl/buffer_load_arbiter.sv
// Round-robin arbiter and load sequencer for one shared buffer register.
// Grants one requester per LOAD cycle and never overwrites a word that has not been taken.
module buffer_load_arbiter #(
   parameter  int WIDTH = 8,
   parameter  int N     = 4,
   localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic               C,
   input  logic               R,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] din,
   input  logic               take,
   output logic [N-1:0]       gnt,
   output logic               L,
   output logic [WIDTH-1:0]   bus,
   output logic               valid,
   output logic [IW-1:0]      owner,
   output logic [7:0]         cnt
);

   typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_FULL} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [N-1:0]    r_gnt;
   logic            r_L;
   logic            r_valid;
   logic [IW-1:0]   r_owner;
   logic [7:0]      r_cnt;
   logic [IW-1:0]   r_prio;
   logic [IW-1:0]   r_sel;

   logic            w_any;
   logic [IW-1:0]   w_win;
   logic [N-1:0]    w_gnt_n;
   logic            w_L_n;
   logic            w_valid_n;
   logic [IW-1:0]   w_owner_n;
   logic [7:0]      w_cnt_n;
   logic [IW-1:0]   w_prio_n;
   logic [IW-1:0]   w_sel_n;

   // Scan from the highest offset down so the lowest offset from r_prio wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = N - 1; k >= 0; k--) begin
         int idx;
         idx = int'(r_prio) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx[IW-1:0]]) begin
            w_any = 1'b1;
            w_win = idx[IW-1:0];
         end
      end
   end

   always_ff @(posedge C) begin
      if (R) r_state <= S_EMPTY;
      else   r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_EMPTY: if (w_any) w_next = S_LOAD;
         S_LOAD:  w_next = S_FULL;
         S_FULL:  if (take) w_next = w_any ? S_LOAD : S_EMPTY;
         default: w_next = S_EMPTY;
      endcase
   end

   always_comb begin
      w_gnt_n   = r_gnt;
      w_L_n     = r_L;
      w_valid_n = r_valid;
      w_owner_n = r_owner;
      w_cnt_n   = r_cnt;
      w_prio_n  = r_prio;
      w_sel_n   = r_sel;
      if (w_next == S_LOAD) begin
         w_gnt_n   = N'(1) << w_win;
         w_L_n     = 1'b1;
         w_valid_n = 1'b0;
         w_sel_n   = w_win;
         w_prio_n  = (w_win == IW'(N - 1)) ? '0 : w_win + IW'(1);
      end else if (r_state == S_LOAD) begin
         w_gnt_n   = '0;
         w_L_n     = 1'b0;
         w_valid_n = 1'b1;
         w_owner_n = r_sel;
         w_cnt_n   = r_cnt + 8'd1;
      end else if (w_next == S_EMPTY) begin
         w_valid_n = 1'b0;
      end
   end

   always_ff @(posedge C) begin
      if (R) begin
         r_gnt   <= '0;
         r_L     <= 1'b0;
         r_valid <= 1'b0;
         r_owner <= '0;
         r_cnt   <= '0;
         r_prio  <= '0;
         r_sel   <= '0;
      end else begin
         r_gnt   <= w_gnt_n;
         r_L     <= w_L_n;
         r_valid <= w_valid_n;
         r_owner <= w_owner_n;
         r_cnt   <= w_cnt_n;
         r_prio  <= w_prio_n;
         r_sel   <= w_sel_n;
      end
   end

   assign bus   = din[r_sel*WIDTH +: WIDTH];
   assign gnt   = r_gnt;
   assign L     = r_L;
   assign valid = r_valid;
   assign owner = r_owner;
   assign cnt   = r_cnt;

endmodule

// File: tb/tb_buffer_load_arbiter.sv
// Directed bench for buffer_load_arbiter with a model of the external buffer register.
module tb_buffer_load_arbiter;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int IW    = 2;

   logic               C = 1'b0;
   logic               R;
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] din;
   logic               take;
   logic [N-1:0]       gnt;
   logic               L;
   logic [WIDTH-1:0]   bus;
   logic               valid;
   logic [IW-1:0]      owner;
   logic [7:0]         cnt;

   logic [WIDTH-1:0]   tb_buf;
   int                 n_chk  = 0;
   int                 n_pass = 0;

   buffer_load_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
      .C(C), .R(R), .req(req), .din(din), .take(take),
      .gnt(gnt), .L(L), .bus(bus), .valid(valid), .owner(owner), .cnt(cnt)
   );

   always #5 C = ~C;

   // External buffer register: captures bus at every edge where L is high.
   always @(posedge C) if (L) tb_buf <= bus;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   initial begin
      R = 1'b1; req = '0; take = 1'b0;
      din = {8'h44, 8'h33, 8'h22, 8'h11};
      tick(); tick();
      chk("rst_gnt", gnt, 0); chk("rst_L", L, 0); chk("rst_valid", valid, 0);
      chk("rst_owner", owner, 0); chk("rst_cnt", cnt, 0);
      R = 1'b0;

      // single load from requester 2
      din[2*WIDTH +: WIDTH] = 8'hB3;
      req = 4'b0100;
      tick();
      chk("t1_L", L, 1); chk("t1_gnt", gnt, 4'b0100); chk("t1_valid_ld", valid, 0);
      chk("t1_bus", bus, 8'hB3);
      tick();
      req = '0;
      chk("t1_Loff", L, 0); chk("t1_gnt0", gnt, 0); chk("t1_valid", valid, 1);
      chk("t1_owner", owner, 2); chk("t1_buf", tb_buf, 8'hB3); chk("t1_cnt", cnt, 1);

      // FULL holds off a pending request until take
      din[1*WIDTH +: WIDTH] = 8'hE5;
      req = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2_hold_L", L, 0);
      end
      chk("t2_hold_gnt", gnt, 0); chk("t2_hold_buf", tb_buf, 8'hB3); chk("t2_hold_valid", valid, 1);
      take = 1'b1;
      tick();
      take = 1'b0;
      chk("t2_L", L, 1); chk("t2_gnt", gnt, 4'b0010); chk("t2_valid_ld", valid, 0);
      tick();
      req = '0;
      chk("t2_buf", tb_buf, 8'hE5); chk("t2_owner", owner, 1); chk("t2_cnt", cnt, 2);

      // all requesters with take held: round robin, one load every 2 cycles
      din = {8'h44, 8'h33, 8'h22, 8'h11};
      R = 1'b1;
      tick();
      R = 1'b0; req = 4'b1111; take = 1'b1;
      for (int g = 0; g < 6; g++) begin
         tick();
         chk("t3_L", L, 1); chk("t3_gnt", gnt, 32'(4'b0001 << (g % 4)));
         tick();
         chk("t3_Loff", L, 0); chk("t3_owner", owner, 32'(g % 4));
         chk("t3_buf", tb_buf, 32'(8'h11 * ((g % 4) + 1))); chk("t3_cnt", cnt, 32'(g + 1));
      end
      req = '0;
      tick();
      chk("t3_empty_valid", valid, 0); chk("t3_empty_L", L, 0);

      // prio wrap after a grant to 3
      req = 4'b1000;
      tick();
      chk("t4_gnt3", gnt, 4'b1000);
      req = 4'b1001;
      tick();
      chk("t4_owner3", owner, 3);
      tick();
      chk("t4_gnt0", gnt, 4'b0001);
      tick();
      chk("t4_owner0", owner, 0);
      tick();
      chk("t4_gnt3b", gnt, 4'b1000);
      tick();
      chk("t4_owner3b", owner, 3); chk("t4_buf", tb_buf, 8'h44);
      req = '0;
      tick();
      chk("t4_empty", valid, 0);

      // reset in the middle of a LOAD
      take = 1'b0;
      req = 4'b0100;
      tick();
      chk("t5_L", L, 1);
      R = 1'b1;
      tick();
      chk("t5_L0", L, 0); chk("t5_gnt0", gnt, 0); chk("t5_valid", valid, 0);
      chk("t5_cnt", cnt, 0); chk("t5_owner", owner, 0);
      R = 1'b0; req = 4'b1000;
      tick();
      chk("t5_gnt3", gnt, 4'b1000);
      tick();
      req = '0;
      chk("t5_owner3", owner, 3); chk("t5_cnt1", cnt, 1); chk("t5_buf", tb_buf, 8'h44);

      // 256 back-to-back loads: counter wraps, no grant skipped
      R = 1'b1;
      tick();
      R = 1'b0; req = 4'b1111; take = 1'b1;
      for (int k = 0; k < 256; k++) begin
         tick();
         chk("t6_gnt", gnt, 32'(4'b0001 << (k % 4)));
         tick();
      end
      chk("t6_cnt_wrap", cnt, 0); chk("t6_valid", valid, 1); chk("t6_owner", owner, 3);

      // withdrawn request never loads
      take = 1'b0; req = 4'b0010;
      tick();
      chk("t6_hold_L", L, 0);
      req = '0; take = 1'b1;
      tick();
      chk("t6_wd_L", L, 0); chk("t6_wd_valid", valid, 0);
      take = 1'b0;
      tick();
      chk("t6_wd_L2", L, 0); chk("t6_wd_gnt", gnt, 0); chk("t6_wd_cnt", cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
